// File: rtl/ascii_calc_n.sv
// ascii_calc_n: hex byte-stream calculator sitting between UART RX and TX.
// Parses two DIGITS-wide hex operands and an operator, computes the result,
// and emits it as an ASCII line ("c" + hex digits + CR LF) or "?" CR LF on error.
module ascii_calc_n #(
    parameter int DIGITS = 2
) (
    input  logic                clk12m,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_data_rdy,
    input  logic                tx_busy,
    output logic [7:0]          tx_data,
    output logic                tx_data_rdy,
    output logic [4*DIGITS-1:0] result,
    output logic                carry,
    output logic [4:0]          leds,
    output logic                busy
);

    localparam int W = 4 * DIGITS;
    localparam logic [2:0] LAST_DIGIT = 3'(DIGITS - 1);
    localparam logic [2:0] SEND_LEN   = 3'(DIGITS + 3);
    localparam logic [2:0] ERR_LEN    = 3'd3;
    localparam logic [2:0] CR_IDX     = 3'(DIGITS + 1);
    localparam logic [2:0] DIGIT_END  = 3'(DIGITS);
    localparam logic [7:0] ESC        = 8'h1B;

    typedef enum logic [2:0] {
        S_OP1,
        S_OP2,
        S_OPER,
        S_EXEC,
        S_SEND,
        S_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   op1_q, op1_d;
    logic [W-1:0]   op2_q, op2_d;
    logic [W-1:0]   result_q, result_d;
    logic           carry_q, carry_d;
    logic [7:0]     oper_q, oper_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_rdy_q, tx_rdy_d;

    logic           accept;
    logic           is_digit;
    logic [3:0]     digit;
    logic           is_op;
    logic [W:0]     sum;
    logic [W:0]     diff;
    logic [3:0]     tx_nib;
    logic [7:0]     tx_hex;
    logic [7:0]     send_byte;
    logic [7:0]     err_byte;

    assign busy   = (state_q == S_EXEC) || (state_q == S_SEND) || (state_q == S_ERR);
    assign accept = rx_data_rdy && !busy;

    // Classify the incoming byte as a hex digit and/or an operator.
    always_comb begin
        is_digit = 1'b0;
        digit    = '0;
        is_op    = 1'b0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_digit = 1'b1;
            digit    = rx_data[3:0];
        end else if ((rx_data >= 8'h61 && rx_data <= 8'h66) ||
                     (rx_data >= 8'h41 && rx_data <= 8'h46)) begin
            is_digit = 1'b1;
            digit    = rx_data[3:0] + 4'd9;
        end
        case (rx_data)
            8'h2B, 8'h2D, 8'h26, 8'h7C, 8'h5E: is_op = 1'b1;
            default:                           is_op = 1'b0;
        endcase
    end

    // Arithmetic on the latched operands; bit W is carry (add) or borrow (sub).
    always_comb begin
        sum  = {1'b0, op1_q} + {1'b0, op2_q};
        diff = {1'b0, op1_q} - {1'b0, op2_q};
    end

    // Select the outgoing byte for the current line position.
    always_comb begin
        tx_nib = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == 3'(i + 1)) tx_nib = result_q[4*(DIGITS-1-i) +: 4];
        end
        tx_hex = (tx_nib < 4'd10) ? (8'h30 + {4'h0, tx_nib}) : (8'h57 + {4'h0, tx_nib});
        if (idx_q == 3'd0)            send_byte = carry_q ? 8'h31 : 8'h30;
        else if (idx_q <= DIGIT_END)  send_byte = tx_hex;
        else if (idx_q == CR_IDX)     send_byte = 8'h0D;
        else                          send_byte = 8'h0A;
        case (idx_q)
            3'd0:    err_byte = 8'h3F;
            3'd1:    err_byte = 8'h0D;
            default: err_byte = 8'h0A;
        endcase
    end

    // Next-state and datapath updates for the parser / transmit sequencer.
    always_comb begin
        state_d   = state_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        result_d  = result_q;
        carry_d   = carry_q;
        oper_d    = oper_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        tx_rdy_d  = 1'b0;

        case (state_q)
            S_OP1, S_OP2: begin
                if (accept) begin
                    if (rx_data == ESC) begin
                        state_d = S_OP1;
                        op1_d   = '0;
                        op2_d   = '0;
                        cnt_d   = '0;
                    end else if (is_digit) begin
                        if (state_q == S_OP1) op1_d = (op1_q << 4) | W'(digit);
                        else                  op2_d = (op2_q << 4) | W'(digit);
                        if (cnt_q == LAST_DIGIT) begin
                            cnt_d   = '0;
                            state_d = (state_q == S_OP1) ? S_OP2 : S_OPER;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_OPER: begin
                if (accept) begin
                    if (rx_data == ESC) begin
                        state_d = S_OP1;
                        op1_d   = '0;
                        op2_d   = '0;
                        cnt_d   = '0;
                    end else if (is_op) begin
                        oper_d  = rx_data;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_EXEC: begin
                case (oper_q)
                    8'h2B: {carry_d, result_d} = sum;
                    8'h2D: begin
                        result_d = diff[W-1:0];
                        carry_d  = diff[W];
                    end
                    8'h26: begin result_d = op1_q & op2_q; carry_d = 1'b0; end
                    8'h7C: begin result_d = op1_q | op2_q; carry_d = 1'b0; end
                    8'h5E: begin result_d = op1_q ^ op2_q; carry_d = 1'b0; end
                    default: ;
                endcase
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND, S_ERR: begin
                // The line ends on the edge after the final strobe; the strobe
                // flag itself enforces the idle cycle between bytes.
                if (tx_rdy_q && idx_q == ((state_q == S_SEND) ? SEND_LEN : ERR_LEN)) begin
                    state_d = S_OP1;
                    op1_d   = '0;
                    op2_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (!tx_rdy_q && !tx_busy) begin
                    tx_rdy_d  = 1'b1;
                    tx_data_d = (state_q == S_SEND) ? send_byte : err_byte;
                    idx_d     = idx_q + 3'd1;
                end
            end
            default: state_d = S_OP1;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk12m or posedge rst) begin
        if (rst) begin
            state_q   <= S_OP1;
            op1_q     <= '0;
            op2_q     <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            oper_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            tx_data_q <= '0;
            tx_rdy_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            oper_q    <= oper_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            tx_data_q <= tx_data_d;
            tx_rdy_q  <= tx_rdy_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_data_rdy = tx_rdy_q;
    assign result      = result_q;
    assign carry       = carry_q;
    assign leds        = {carry_q, result_q[3:0]};

endmodule

// File: tb/tb_ascii_calc_n.sv
// Testbench for ascii_calc_n: two instances (DIGITS=2 and DIGITS=1) driven
// through a shared stimulus path and compared against a text-level model.
module tb_ascii_calc_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_rdy = 1'b0;
    logic       tx_busy = 1'b0;
    bit         sel = 1'b0;
    bit         txb_rand = 1'b0;

    logic       rdy2, rdy1;
    logic [7:0] txd2, txd1;
    logic       txr2, txr1;
    logic [7:0] res2;
    logic [3:0] res1;
    logic       cy2, cy1;
    logic [4:0] led2, led1;
    logic       bz2, bz1;

    logic [7:0]  txd_m;
    logic        txr_m;
    logic [15:0] res_m;
    logic        cy_m;
    logic [4:0]  led_m;
    logic        bz_m;

    assign rdy2  = rx_rdy & ~sel;
    assign rdy1  = rx_rdy & sel;
    assign txd_m = sel ? txd1 : txd2;
    assign txr_m = sel ? txr1 : txr2;
    assign res_m = sel ? {12'h0, res1} : {8'h0, res2};
    assign cy_m  = sel ? cy1 : cy2;
    assign led_m = sel ? led1 : led2;
    assign bz_m  = sel ? bz1 : bz2;

    ascii_calc_n #(.DIGITS(2)) dut2 (
        .clk12m(clk), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rdy2),
        .tx_busy(tx_busy), .tx_data(txd2), .tx_data_rdy(txr2),
        .result(res2), .carry(cy2), .leds(led2), .busy(bz2)
    );

    ascii_calc_n #(.DIGITS(1)) dut1 (
        .clk12m(clk), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rdy1),
        .tx_busy(tx_busy), .tx_data(txd1), .tx_data_rdy(txr1),
        .result(res1), .carry(cy1), .leds(led1), .busy(bz1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int proto_err = 0;
    int rd_ptr = 0;
    bit last_rdy = 1'b0;
    bit last_txb = 1'b0;
    logic [7:0] cap_q[$];
    int         cyc_q[$];

    logic [7:0] exp_q[$];
    logic [7:0] mbuf[$];
    int         m_res = 0;
    int         m_cy = 0;
    bit         line_err = 1'b0;
    string      hex_lc = "0123456789abcdef";
    string      hex_any = "0123456789abcdefABCDEF";
    string      op_chars = "+-&|^";
    string      junk_chars = "gGz @!.";

    always @(posedge clk) cyc <= cyc + 1;

    // Transmit monitor: records every strobe and flags handshake violations.
    always @(negedge clk) begin
        if (txr_m) begin
            cap_q.push_back(txd_m);
            cyc_q.push_back(cyc);
            if (last_rdy) proto_err = proto_err + 1;
            if (last_txb) proto_err = proto_err + 1;
        end
        last_rdy = txr_m;
        last_txb = tx_busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46);
    endfunction

    function automatic bit is_op(input logic [7:0] c);
        return c == 8'h2B || c == 8'h2D || c == 8'h26 || c == 8'h7C || c == 8'h5E;
    endfunction

    function automatic int hexval(input logic [7:0] c);
        if (c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h61) return int'(c) - 87;
        return int'(c) - 55;
    endfunction

    // Reference model: buffers the characters of one expression and evaluates
    // it with plain integer arithmetic once it is complete.
    function automatic void model_byte(input logic [7:0] c, input int d);
        int pos;
        bit ok;
        int a, b, r, cy, m;
        if (c == 8'h1B) begin
            mbuf.delete();
            return;
        end
        pos = mbuf.size();
        ok = (pos < 2*d) ? is_hex(c) : is_op(c);
        if (!ok) begin
            exp_q.push_back(8'h3F);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            line_err = 1'b1;
            mbuf.delete();
            return;
        end
        mbuf.push_back(c);
        if (mbuf.size() < 2*d + 1) return;
        a = 0;
        b = 0;
        for (int i = 0; i < d; i++) begin
            a = a * 16 + hexval(mbuf[i]);
            b = b * 16 + hexval(mbuf[d + i]);
        end
        m = 1 << (4*d);
        r = 0;
        cy = 0;
        case (mbuf[2*d])
            8'h2B: begin r = a + b; cy = (r >= m) ? 1 : 0; r = r % m; end
            8'h2D: begin cy = (a < b) ? 1 : 0; r = (a - b + m) % m; end
            8'h26: r = a & b;
            8'h7C: r = a | b;
            default: r = a ^ b;
        endcase
        m_res = r;
        m_cy = cy;
        line_err = 1'b0;
        exp_q.push_back(cy != 0 ? 8'h31 : 8'h30);
        for (int i = d - 1; i >= 0; i--) exp_q.push_back(hex_lc[(r >> (4*i)) & 15]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        mbuf.delete();
    endfunction

    function automatic logic [7:0] rand_byte(input int pos, input int d);
        int unsigned k;
        k = $urandom_range(0, 99);
        if (k < 3) return 8'h1B;
        if (k < 7) return junk_chars[$urandom_range(0, junk_chars.len() - 1)];
        if (pos < 2*d) return hex_any[$urandom_range(0, hex_any.len() - 1)];
        return op_chars[$urandom_range(0, op_chars.len() - 1)];
    endfunction

    task automatic send_byte(input logic [7:0] c);
        rx_data = c;
        rx_rdy = 1'b1;
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_line(input bit inject, input bit hold);
        int unsigned t;
        int n;
        int c0;
        bit held;
        t = 0;
        held = 1'b0;
        if (inject) begin rx_data = 8'($urandom); rx_rdy = 1'b1; end
        tx_busy = txb_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        if (!line_err) begin
            check("exec_result", 32'(res_m), 32'(m_res));
            check("exec_busy", 32'(bz_m), 32'd1);
        end
        while (cap_q.size() - rd_ptr < exp_q.size() && t < 500) begin
            if (hold && !held && cap_q.size() - rd_ptr >= 2) begin
                held = 1'b1;
                tx_busy = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                c0 = cap_q.size();
                repeat (18) @(posedge clk);
                #1;
                check("hold_quiet", 32'(cap_q.size()), 32'(c0));
                tx_busy = 1'b0;
            end
            if (inject) begin rx_data = 8'($urandom); rx_rdy = 1'b1; end
            if (!hold) tx_busy = txb_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge clk);
            #1;
            rx_rdy = 1'b0;
            t++;
        end
        @(posedge clk);
        #1;
        tx_busy = 1'b0;
        n = exp_q.size();
        check("line_len", 32'(cap_q.size() - rd_ptr), 32'(n));
        for (int i = 0; i < n && rd_ptr + i < cap_q.size(); i++)
            check("tx_byte", 32'(cap_q[rd_ptr + i]), 32'(exp_q[i]));
        if (!txb_rand && !hold && cap_q.size() - rd_ptr >= n) begin
            check("first_latency", 32'(cyc_q[rd_ptr] - acc_cyc), line_err ? 32'd1 : 32'd2);
            check("line_span", 32'(cyc_q[rd_ptr + n - 1] - cyc_q[rd_ptr]), 32'(2*(n - 1)));
        end
        check("result", 32'(res_m), 32'(m_res));
        check("carry", 32'(cy_m), 32'(m_cy));
        check("leds", 32'(led_m), 32'({m_cy[0], m_res[3:0]}));
        check("busy_idle", 32'(bz_m), 32'd0);
        check("tx_protocol", 32'(proto_err), 32'd0);
        rd_ptr = cap_q.size();
        exp_q.delete();
    endtask

    task automatic send_and_model(input logic [7:0] c, input bit inject, input bit hold);
        send_byte(c);
        model_byte(c, sel ? 1 : 2);
        if (exp_q.size() > 0) wait_line(inject, hold);
    endtask

    task automatic run_str(input string s, input bit inject, input bit hold);
        for (int i = 0; i < s.len(); i++) send_and_model(s[i], inject, hold);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_tx_data"}, 32'(txd_m), 32'd0);
        check({pfx, "_tx_rdy"}, 32'(txr_m), 32'd0);
        check({pfx, "_result"}, 32'(res_m), 32'd0);
        check({pfx, "_carry"}, 32'(cy_m), 32'd0);
        check({pfx, "_leds"}, 32'(led_m), 32'd0);
        check({pfx, "_busy"}, 32'(bz_m), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        logic [7:0] c;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed sequences, DIGITS=2.
        run_str("3c05+", 1'b0, 1'b0);
        run_str("0203-", 1'b0, 1'b0);
        run_str("FF01+", 1'b0, 1'b0);
        run_str("3c05+", 1'b0, 1'b0);
        run_str("1g", 1'b0, 1'b0);
        run_str("aa0f&", 1'b0, 1'b0);
        run_str("1\0331122^", 1'b0, 1'b0);
        run_str("12ab|", 1'b1, 1'b1);
        run_str("7e91+", 1'b1, 1'b0);

        // Reset in the middle of a line.
        run_str("3c05", 1'b0, 1'b0);
        send_byte(8'h2B);
        model_byte(8'h2B, 2);
        t = 0;
        while (cap_q.size() - rd_ptr < 2 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("pre_rst_bytes", 32'(cap_q.size() - rd_ptr), 32'd2);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_ptr = cap_q.size();
        exp_q.delete();
        mbuf.delete();
        m_res = 0;
        m_cy = 0;
        @(posedge clk);
        #1;
        run_str("1234+", 1'b0, 1'b0);

        // Randomized traffic, DIGITS=2.
        for (int k = 0; k < 160; k++) begin
            txb_rand = (k >= 80);
            c = rand_byte(mbuf.size(), 2);
            send_and_model(c, 1'($urandom_range(0, 1)), 1'b0);
        end
        txb_rand = 1'b0;

        // DIGITS=1 instance; it has been idle since reset.
        sel = 1'b1;
        mbuf.delete();
        m_res = 0;
        m_cy = 0;
        @(posedge clk);
        #1;
        run_str("52-", 1'b0, 1'b0);
        run_str("23-", 1'b0, 1'b0);
        run_str("f1+", 1'b0, 1'b0);
        for (int k = 0; k < 80; k++) begin
            txb_rand = (k >= 40);
            c = rand_byte(mbuf.size(), 1);
            send_and_model(c, 1'($urandom_range(0, 1)), 1'b0);
        end
        txb_rand = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
